// File: rtl/mm_pkg.sv
// Shared types and default sizes for the tiled matrix-multiply scheduler.
package mm_pkg;

    localparam int N_DEF     = 16;
    localparam int IDX_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB,
        FINISH
    } sched_state_t;

    typedef logic [IDX_W_DEF-1:0] tile_idx_t;

endpackage

// File: rtl/mm_tile_counter.sv
// Nested i/j/k tile index counter; k innermost, j middle, i outermost.
module mm_tile_counter
    import mm_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step_k,
    input  logic             step_ij,
    input  logic [IDX_W-1:0] dim_i,
    input  logic [IDX_W-1:0] dim_j,
    input  logic [IDX_W-1:0] dim_k,
    output logic [IDX_W-1:0] ti,
    output logic [IDX_W-1:0] tj,
    output logic [IDX_W-1:0] tk,
    output logic             last_k,
    output logic             last_ij
);

    // Last legal index of each loop, captured at load so compares never wrap.
    logic [IDX_W-1:0] i_max;
    logic [IDX_W-1:0] j_max;
    logic [IDX_W-1:0] k_max;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_max <= '0;
            j_max <= '0;
            k_max <= '0;
            ti    <= '0;
            tj    <= '0;
            tk    <= '0;
        end else if (load) begin
            i_max <= dim_i - 1'b1;
            j_max <= dim_j - 1'b1;
            k_max <= dim_k - 1'b1;
            ti    <= '0;
            tj    <= '0;
            tk    <= '0;
        end else if (step_ij) begin
            tk <= '0;
            if (tj != j_max) begin
                tj <= tj + 1'b1;
            end else begin
                tj <= '0;
                if (ti != i_max) begin
                    ti <= ti + 1'b1;
                end
            end
        end else if (step_k) begin
            tk <= tk + 1'b1;
        end
    end

    assign last_k  = (tk == k_max);
    assign last_ij = (ti == i_max) && (tj == j_max);

endmodule

// File: rtl/mm_tile_scheduler.sv
// Sequences compute_unit over every (i,j,k) tile step and hands each finished
// output tile to the writeback port; reports busy/done/err and busy cycles.
module mm_tile_scheduler
    import mm_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int IDX_W = IDX_W_DEF,
    parameter int CYC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W-1:0] tiles_i,
    input  logic [IDX_W-1:0] tiles_j,
    input  logic [IDX_W-1:0] tiles_k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             cu_start,
    output logic             cu_acc_clr,
    output logic [IDX_W-1:0] cu_ti,
    output logic [IDX_W-1:0] cu_tj,
    output logic [IDX_W-1:0] cu_tk,
    input  logic             cu_done,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [IDX_W-1:0] wb_ti,
    output logic [IDX_W-1:0] wb_tj,
    output logic [CYC_W-1:0] cycle_count
);

    if (N < 1) begin : g_n_check
        $error("mm_tile_scheduler: N must be at least 1");
    end

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic             load;
    logic             step_k;
    logic             step_ij;
    logic             zero_dim;
    logic             last_k;
    logic             last_ij;
    logic [IDX_W-1:0] ti;
    logic [IDX_W-1:0] tj;
    logic [IDX_W-1:0] tk;

    assign zero_dim = (tiles_i == '0) || (tiles_j == '0) || (tiles_k == '0);

    mm_tile_counter #(
        .IDX_W (IDX_W)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step_k  (step_k),
        .step_ij (step_ij),
        .dim_i   (tiles_i),
        .dim_j   (tiles_j),
        .dim_k   (tiles_k),
        .ti      (ti),
        .tj      (tj),
        .tk      (tk),
        .last_k  (last_k),
        .last_ij (last_ij)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step_k    = 1'b0;
        step_ij   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = zero_dim ? FINISH : ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (cu_done) begin
                    if (last_k) begin
                        state_nxt = WB;
                    end else begin
                        step_k    = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            WB: begin
                if (wb_ready) begin
                    step_ij   = 1'b1;
                    state_nxt = last_ij ? FINISH : ISSUE;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort outranks every transition once a job is running.
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            step_k    = 1'b0;
            step_ij   = 1'b0;
        end
    end

    // The accepting cycle counts as the first busy cycle of the job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err         <= 1'b0;
            cycle_count <= '0;
        end else if (load) begin
            err         <= zero_dim;
            cycle_count <= CYC_W'(1);
        end else begin
            if (abort && (state != IDLE)) begin
                err <= 1'b1;
            end
            if (busy && (cycle_count != '1)) begin
                cycle_count <= cycle_count + 1'b1;
            end
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == FINISH) && !abort;
    assign cu_start   = (state == ISSUE);
    assign cu_acc_clr = cu_start && (tk == '0);
    assign cu_ti      = ti;
    assign cu_tj      = tj;
    assign cu_tk      = tk;
    assign wb_valid   = (state == WB);
    assign wb_ti      = ti;
    assign wb_tj      = tj;

endmodule

// File: tb/tb_mm_tile_scheduler.sv
// Bench for mm_tile_scheduler: directed scenarios plus randomized jobs checked
// against a loop-nest reference of the expected step, writeback and cycle totals.
module tb_mm_tile_scheduler;

    localparam int IDX_W = 8;
    localparam int CYC_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [IDX_W-1:0] tiles_i;
    logic [IDX_W-1:0] tiles_j;
    logic [IDX_W-1:0] tiles_k;
    logic             busy;
    logic             done;
    logic             err;
    logic             cu_start;
    logic             cu_acc_clr;
    logic [IDX_W-1:0] cu_ti;
    logic [IDX_W-1:0] cu_tj;
    logic [IDX_W-1:0] cu_tk;
    logic             cu_done;
    logic             wb_valid;
    logic             wb_ready;
    logic [IDX_W-1:0] wb_ti;
    logic [IDX_W-1:0] wb_tj;
    logic [CYC_W-1:0] cycle_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mm_tile_scheduler #(
        .N     (16),
        .IDX_W (IDX_W),
        .CYC_W (CYC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .tiles_i     (tiles_i),
        .tiles_j     (tiles_j),
        .tiles_k     (tiles_k),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .cu_start    (cu_start),
        .cu_acc_clr  (cu_acc_clr),
        .cu_ti       (cu_ti),
        .cu_tj       (cu_tj),
        .cu_tk       (cu_tk),
        .cu_done     (cu_done),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_ti       (wb_ti),
        .wb_tj       (wb_tj),
        .cycle_count (cycle_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_cu_start"}, {cu_start, cu_acc_clr, wb_valid}, 0);
        check({tag, "_idx"}, {cu_ti, cu_tj, cu_tk, wb_ti, wb_tj}, 0);
        check({tag, "_cycle_count"}, cycle_count, 0);
    endtask

    // Runs one job with nonzero dims. lat>0 fixes the cu_done latency (else random 1..4);
    // first_stall>=0 fixes the wb_ready delay on the first tile (else random 0..3).
    task automatic run_job(input int di, input int dj, input int dk,
                           input int lat, input int first_stall, input bit mid_start);
        logic [3*IDX_W-1:0] exp_steps[$];
        logic [2*IDX_W-1:0] exp_wb[$];
        logic [3*IDX_W-1:0] cur_step;
        logic [2*IDX_W-1:0] cur_wb;
        int ecc, n_cu, n_wb, n_done, wait_cnt, stall, cyc;
        bit in_wait, in_wb, finished;
        for (int i = 0; i < di; i++) begin
            for (int j = 0; j < dj; j++) begin
                exp_wb.push_back({IDX_W'(i), IDX_W'(j)});
                for (int k = 0; k < dk; k++) begin
                    exp_steps.push_back({IDX_W'(i), IDX_W'(j), IDX_W'(k)});
                end
            end
        end
        cur_step = '0; cur_wb = '0;
        ecc = 1; n_cu = 0; n_wb = 0; n_done = 0; wait_cnt = 0; stall = 0; cyc = 0;
        in_wait = 0; in_wb = 0; finished = 0;
        @(negedge clk);
        start = 1'b1;
        tiles_i = IDX_W'(di); tiles_j = IDX_W'(dj); tiles_k = IDX_W'(dk);
        while (!finished && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start   = 1'b0;
            cu_done = 1'b0;
            tiles_i = IDX_W'($urandom); tiles_j = IDX_W'($urandom); tiles_k = IDX_W'($urandom);
            if (cyc == 1) begin
                check("first_cu_start_latency", cu_start, 1);
                check("busy_after_start", busy, 1);
                check("err_cleared_on_start", err, 0);
            end
            if (cu_start) begin
                if (exp_steps.size() > 0) cur_step = exp_steps.pop_front();
                else cur_step = '1;
                check("cu_idx", {cu_ti, cu_tj, cu_tk}, cur_step);
                check("cu_acc_clr", cu_acc_clr, (cur_step[IDX_W-1:0] == 0));
                n_cu++;
                wait_cnt = (lat > 0) ? lat : int'($urandom_range(1, 4));
                ecc += 1 + wait_cnt;
                in_wait = 1;
            end else if (in_wait) begin
                check("cu_idx_stable", {cu_ti, cu_tj, cu_tk}, cur_step);
                wait_cnt--;
                if (wait_cnt == 0) begin
                    cu_done = 1'b1;
                    in_wait = 0;
                end
            end
            if (wb_valid) begin
                if (!in_wb) begin
                    in_wb = 1;
                    if (exp_wb.size() > 0) cur_wb = exp_wb.pop_front();
                    else cur_wb = '1;
                    stall = (n_wb == 0 && first_stall >= 0) ? first_stall : int'($urandom_range(0, 3));
                    ecc += stall + 1;
                end
                check("wb_idx", {wb_ti, wb_tj}, cur_wb);
                check("no_cu_start_in_wb", cu_start, 0);
                wb_ready = (stall == 0);
                if (stall == 0) begin
                    in_wb = 0;
                    n_wb++;
                end else begin
                    stall--;
                end
            end else begin
                if (in_wb) begin
                    check("wb_valid_held", wb_valid, 1);
                    in_wb = 0;
                end
                wb_ready = 1'b0;
            end
            if (done) begin
                n_done++;
                ecc++;
                finished = 1;
                check("done_err", err, 0);
            end
            if (mid_start && cyc == 3) start = 1'b1;
        end
        check("job_finished", finished, 1);
        @(negedge clk);
        start = 1'b0; cu_done = 1'b0; wb_ready = 1'b0;
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("cycle_count", cycle_count, ecc);
        check("cu_start_total", n_cu, di * dj * dk);
        check("wb_total", n_wb, di * dj);
        check("done_total", n_done, 1);
        check("err_after_job", err, 0);
    endtask

    initial begin
        int  seen, cyc, nwb;
        bit  done_seen, pend;
        rst = 1'b0; start = 1'b0; abort = 1'b0; cu_done = 1'b0; wb_ready = 1'b0;
        tiles_i = '0; tiles_j = '0; tiles_k = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Single tile, fixed latency 5, sink always ready.
        run_job(1, 1, 1, 5, 0, 1'b0);
        // 2x2x3 with an ignored second start mid-job.
        run_job(2, 2, 3, 0, -1, 1'b1);
        // First writeback held off for 10 cycles.
        run_job(2, 1, 2, 2, 10, 1'b0);

        // Abort during WAIT of the third step of a 2x2x2 job.
        @(negedge clk);
        start = 1'b1; tiles_i = 2; tiles_j = 2; tiles_k = 2;
        seen = 0; cyc = 0; done_seen = 0; pend = 0;
        @(negedge clk);
        start = 1'b0;
        while (seen < 3 && cyc < 200) begin
            cu_done = pend; pend = 0;
            wb_ready = wb_valid;
            if (done) done_seen = 1;
            if (cu_start) begin
                seen++;
                pend = 1;
            end
            if (seen < 3) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("abort_reached_step3", seen, 3);
        @(negedge clk);
        cu_done = 1'b0; wb_ready = 1'b0;
        check("abort_pre_in_wait", {busy, cu_start}, 2'b10);
        abort = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_err", err, 1);
        check("abort_done", done, 0);
        check("abort_outputs", {cu_start, wb_valid}, 0);
        abort = 1'b0; cu_done = 1'b1;
        @(negedge clk);
        cu_done = 1'b0;
        check("late_cu_done_ignored", {busy, cu_start, done}, 0);
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen = 1;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_idle_busy", busy, 0);

        // Abort while idle leaves the job state and err alone.
        abort = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_abort_busy", busy, 0);
        check("idle_abort_err", err, 1);
        // Start beats a simultaneous abort; the abort still held next cycle cancels.
        start = 1'b1; tiles_i = 1; tiles_j = 1; tiles_k = 1;
        @(negedge clk);
        start = 1'b0;
        check("start_wins_busy", busy, 1);
        check("start_wins_err", err, 0);
        @(negedge clk);
        check("held_abort_cancels", {busy, err, done, cu_start}, 4'b0100);
        abort = 1'b0;
        // A new start clears err (checked inside run_job).
        run_job(1, 1, 1, 1, 0, 1'b0);

        // Zero reduction dimension takes the error path.
        @(negedge clk);
        start = 1'b1; tiles_i = 3; tiles_j = 2; tiles_k = 0;
        @(negedge clk);
        start = 1'b0;
        check("zero_dim_done", done, 1);
        check("zero_dim_err", err, 1);
        check("zero_dim_busy", busy, 1);
        check("zero_dim_no_work", {cu_start, wb_valid}, 0);
        @(negedge clk);
        check("zero_dim_idle", {busy, done, cu_start, wb_valid}, 0);
        check("zero_dim_err_sticky", err, 1);
        check("zero_dim_cycle_count", cycle_count, 2);

        // Asynchronous reset while the second writeback is pending.
        @(negedge clk);
        start = 1'b1; tiles_i = 1; tiles_j = 2; tiles_k = 1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; nwb = 0; pend = 0;
        while (cyc < 200) begin
            cu_done = pend; pend = 0; wb_ready = 1'b0;
            if (cu_start) pend = 1;
            if (wb_valid) begin
                if (nwb == 0) begin
                    wb_ready = 1'b1;
                    nwb = 1;
                end else begin
                    break;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("rst_reached_wb", wb_valid, 1);
        check("rst_wb_idx", {wb_ti, wb_tj}, {8'd0, 8'd1});
        #2 rst = 1'b0;
        #1 check_all_zero("mid_job_rst");
        @(negedge clk);
        rst = 1'b1;
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) done_seen = 1;
        end
        check("rst_no_done", done_seen, 0);

        // Maximum-count indices must not wrap.
        run_job(1, 1, 255, 1, 0, 1'b0);
        run_job(1, 255, 1, 1, -1, 1'b0);

        // Randomized jobs.
        for (int r = 0; r < 8; r++) begin
            run_job(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                    int'($urandom_range(1, 3)), 0, -1, r[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
